pcm_interp: RTL and testbench
=============================

# pcm_interp

Upstream feeder for `delta_sigma_dac`:
- Accepts audio samples at the audio rate (~48 kHz) through a valid/ready handshake and buffers them in a small FIFO.
- Drives the DAC's `pcm_in` every clock with a linearly interpolated value, replacing the staircase of a held sample with a ramp between consecutive samples.
- Tracks input starvation and reports it.

## Interface
Parameters:
- `DATA_W`, 16, sample width; two's complement, same format as DAC `pcm_in`.
- `RATIO_LOG2`, 10, log2 of clocks per input sample (1024 clk at 50 MHz ≈ 48.8 kHz).
- `FIFO_DEPTH`, 4, input FIFO entries (power of two).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  DATA_W  input sample.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  FIFO can accept; transfer when `s_valid && s_ready` at the rising edge.
- `pcm_out`  out  DATA_W  interpolated sample; connects to `delta_sigma_dac.pcm_in`.
- `sample_tick`  out  1  one-cycle pulse at each phase wrap, i.e. at each segment start.
- `underrun`  out  1  one-cycle pulse when a wrap finds the FIFO empty in RUN.

## Operation
Registers:
- `cur` (last target sample), `delta` (DATA_W+1 signed).
- `acc` (DATA_W+RATIO_LOG2+1 signed).
- `phase` (RATIO_LOG2 bits).
- FIFO read/write pointers plus count.

Output: `pcm_out = acc >>> RATIO_LOG2` (arithmetic shift, floor), registered.

Segment load (pop), performed when the FIFO is non-empty at a load point:
- `delta <= head - cur`
- `acc <= cur <<< RATIO_LOG2`
- `cur <= head`
- `phase <= 0`
- pulse `sample_tick`

Each non-wrap cycle in RUN: `acc <= acc + delta`, `phase <= phase + 1`.

After 2^RATIO_LOG2 cycles `acc` equals `cur <<< RATIO_LOG2` exactly. Intermediate values lie between the endpoints, so no overflow or saturation logic is needed.

FSM:
- IDLE (reset state):
  - phase stopped, `pcm_out` = 0, `cur` = 0.
  - On the first cycle the FIFO is non-empty: load segment → RUN.
- RUN:
  - On wrap (`phase` = all-ones) with FIFO non-empty: load next segment, stay in RUN.
  - On wrap with FIFO empty: `delta <= 0`, `acc <= cur <<< RATIO_LOG2`, pulse `underrun` and `sample_tick` → STARVED.
- STARVED:
  - `pcm_out` holds `cur`; phase keeps counting.
  - On wrap with FIFO non-empty: load segment → RUN.
  - On wrap with FIFO empty: stay; no further `underrun` pulses.

FIFO:
- `s_ready = (count != FIFO_DEPTH)`.
- Push and pop in the same cycle are allowed; count unchanged.
- No bypass: a sample pushed in cycle N is poppable at the earliest in cycle N+1.

## Timing
- Reset values: `pcm_out` 0, `s_ready` 1, `sample_tick` 0, `underrun` 0; FIFO empty, state IDLE.
- Reset is asynchronous and takes effect immediately mid-segment; FIFO contents are discarded.
- IDLE latency: a sample accepted at edge N is popped at edge N+1. `pcm_out` takes its first ramp step at edge N+2 and reaches the sample at edge N+1+2^RATIO_LOG2.
- Output rate: one `pcm_out` update per clock in RUN. Segment boundaries are fixed every 2^RATIO_LOG2 clocks after the first load.
- Full FIFO: `s_ready` is low; the upstream holds `s_data`/`s_valid` until `s_ready` rises. It rises on the cycle after a pop.

## Structure
- `audio_pkg` holds `DATA_W`, the `pcm_t` sample typedef, and the `interp_state_t` enum (IDLE/RUN/STARVED). `delta_sigma_dac` shares `pcm_t`.
- Sub-module `sample_fifo`: synchronous FIFO with parameters `DATA_W` and `FIFO_DEPTH`, ports push/pop/full/empty/count. The interpolator FSM and accumulator stay in `pcm_interp`.

## Test plan
All cases use RATIO_LOG2=3 (8 clk/sample), FIFO_DEPTH=4.
- Reset: assert `rst` → `pcm_out`=0x0000, `s_ready`=1, `underrun`=0, `sample_tick`=0.
- Ramp up: from IDLE push 0x0800 → `pcm_out` steps 0x0100, 0x0200 … 0x0800 over 8 clocks; `sample_tick` pulses once at load.
- Signed ramp down: push 0x0800 then 0xF800 → second segment decrements by 0x0200 per clock, ending exactly at 0xF800; no wrap-around glitch.
- Backpressure: hold `s_valid` high and push 5 samples without pops → `s_ready` low after 4 accepted. The 5th is accepted the cycle after the next wrap pop, with data unchanged.
- Starvation: stop input after one sample → at the next wrap `underrun` pulses once and `pcm_out` holds 0x0800 across several wraps. Push 0x0000 → ramp resumes at the next wrap, stepping by 0xFF00.
- Reset mid-ramp: assert `rst` at phase 4 with 2 samples queued → `pcm_out`=0 immediately, FIFO empty; after release, state is IDLE.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path types: sample width, PCM sample type, interpolator states.
// Latency: n/a (types only).
// Backpressure: n/a.
package audio_pkg;

  localparam int DATA_W = 16;

  // Two's-complement PCM sample, same format as delta_sigma_dac.pcm_in.
  typedef logic signed [DATA_W-1:0] pcm_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STARVED
  } interp_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO, power-of-two depth, registered storage.
// Latency: a push at edge N is visible on pop_data/!empty from edge N (poppable in cycle N+1); no bypass.
// Backpressure: push ignored while full, pop ignored while empty; simultaneous push+pop keeps count.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data write request and data
//   pop, pop_data   read request; pop_data is the current head (show-ahead)
//   full, empty     occupancy flags
//   count           number of stored entries, 0..FIFO_DEPTH
module sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    // Pointers wrap naturally because the depth is a power of two.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only reachable through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pcm_interp.sv
// Linear interpolator feeding delta_sigma_dac: ramps pcm_out between consecutive input samples.
// Latency: sample accepted at edge N loads at N+1 (from IDLE), first ramp step at N+2, target at N+1+2^RATIO_LOG2.
// Backpressure: s_ready low while the FIFO holds FIFO_DEPTH samples; rises the cycle after a segment pop.
//
// Ports:
//   clk, rst      single clock; asynchronous active-high reset
//   s_data        input sample (two's complement), s_valid/s_ready handshake
//   pcm_out       registered interpolated sample, one update per clock
//   sample_tick   one-cycle pulse at each segment start (and at the wrap that enters starvation)
//   underrun      one-cycle pulse when a RUN wrap finds the FIFO empty
module pcm_interp #(
  parameter int DATA_W     = 16,
  parameter int RATIO_LOG2 = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] pcm_out,
  output logic              sample_tick,
  output logic              underrun
);

  import audio_pkg::*;

  localparam int ACC_W = DATA_W + RATIO_LOG2 + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  assign s_ready   = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_push = s_valid && !fifo_full;

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  interp_state_t         state_q, state_d;
  logic [DATA_W-1:0]     cur_q, cur_d;
  logic [DATA_W:0]       delta_q, delta_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [RATIO_LOG2-1:0] phase_q, phase_d;
  logic [DATA_W-1:0]     pcm_q, pcm_d;
  logic                  tick_q, tick_d;
  logic                  underrun_q, underrun_d;

  logic             wrap, load;
  logic [ACC_W-1:0] cur_scaled, delta_ext;

  assign wrap       = (phase_q == '1);
  // cur <<< RATIO_LOG2, sign-extended to the accumulator width.
  assign cur_scaled = {cur_q[DATA_W-1], cur_q, {RATIO_LOG2{1'b0}}};
  assign delta_ext  = {{RATIO_LOG2{delta_q[DATA_W]}}, delta_q};

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    delta_d    = delta_q;
    acc_d      = acc_q;
    phase_d    = phase_q;
    tick_d     = 1'b0;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        load = !fifo_empty;
      end
      RUN, STARVED: begin
        if (wrap) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            // Park on the last target; only the RUN->STARVED wrap is reported.
            delta_d    = '0;
            acc_d      = cur_scaled;
            phase_d    = '0;
            tick_d     = (state_q == RUN);
            underrun_d = (state_q == RUN);
            state_d    = STARVED;
          end
        end else begin
          // In STARVED delta is zero, so this just holds the output.
          acc_d   = acc_q + delta_ext;
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      // acc restarts exactly on the previous target, so rounding error never
      // carries across segments.
      fifo_pop = 1'b1;
      delta_d  = {fifo_head[DATA_W-1], fifo_head} - {cur_q[DATA_W-1], cur_q};
      acc_d    = cur_scaled;
      cur_d    = fifo_head;
      phase_d  = '0;
      tick_d   = 1'b1;
      state_d  = RUN;
    end

    // Floor of acc / 2^RATIO_LOG2; intermediate values stay between the endpoints.
    pcm_d = acc_d[RATIO_LOG2 +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      delta_q    <= '0;
      acc_q      <= '0;
      phase_q    <= '0;
      pcm_q      <= '0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      delta_q    <= delta_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      pcm_q      <= pcm_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
    end
  end

  assign pcm_out     = pcm_q;
  assign sample_tick = tick_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_pcm_interp.sv
// Testbench for pcm_interp with 8 clocks per sample and a 4-entry FIFO.
// Accepted samples go to a scoreboard; a negedge monitor pops them at each
// segment start and checks every ramp step, the segment endpoints, and holds.
module tb_pcm_interp;

  localparam int DW = 16;
  localparam int RL = 3;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] pcm_out;
  logic          sample_tick;
  logic          underrun;

  always #5 clk = ~clk;

  pcm_interp #(
    .DATA_W     (DW),
    .RATIO_LOG2 (RL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .pcm_out     (pcm_out),
    .sample_tick (sample_tick),
    .underrun    (underrun)
  );

  typedef struct {
    logic [15:0] din;    // sample value (segment target)
    logic [15:0] first;  // hand-computed pcm_out one clock after the load
  } vec_t;

  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Value k clocks into a segment from a to b: a + floor(k*(b-a)/8).
  function automatic logic [15:0] ramp(input logic [15:0] a, input logic [15:0] b, input int k);
    int d;
    int s;
    d = int'($signed(b)) - int'($signed(a));
    s = int'($signed(a)) + ((k * d) >>> 3);
    return s[15:0];
  endfunction

  // ---------------- monitor ----------------
  int          cyc     = 0;
  int          t0      = 0;
  int          k       = 0;
  int          n_under = 0;
  int          n_tick  = 0;
  bit          active  = 1'b0;
  bit          fresh   = 1'b1;
  vec_t        cur_v;
  logic [15:0] hold_v    = 16'h0000;
  logic [15:0] seg_start = 16'h0000;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      active = 1'b0;
      fresh  = 1'b1;
      hold_v = 16'h0000;
      sb.delete();
    end else begin
      if (underrun && !sample_tick) fail("underrun_without_tick");
      if (sample_tick) begin
        n_tick++;
        seg_start = active ? cur_v.din : hold_v;
        check("seg_boundary", pcm_out, seg_start);
        if (fresh) begin
          t0    = cyc;
          fresh = 1'b0;
        end else begin
          check("tick_on_grid", (cyc - t0) % 8, 0);
        end
        if (underrun) begin
          n_under++;
          check("underrun_while_running", active, 1);
          hold_v = seg_start;
          active = 1'b0;
        end else if (sb.size() == 0) begin
          fail("load_without_sample");
        end else begin
          cur_v  = sb.pop_front();
          active = 1'b1;
          k      = 0;
        end
      end else if (active) begin
        k++;
        if (k >= 8) begin
          fail("missing_segment_tick");
          active = 1'b0;
          hold_v = pcm_out;
        end else if (k == 1) begin
          check("ramp_first", pcm_out, cur_v.first);
        end else begin
          check("ramp_step", pcm_out, ramp(seg_start, cur_v.din, k));
        end
      end else begin
        check("hold", pcm_out, hold_v);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [15:0] d, input logic [15:0] f, output int stall);
    bit rdy;
    int guard;
    s_data  = d;
    s_valid = 1'b1;
    stall   = 0;
    guard   = 0;
    do begin
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (!rdy) stall++;
      guard++;
    end while (!rdy && guard < 100);
    if (!rdy) fail("send_timeout");
    else sb.push_back('{d, f});
    s_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  vec_t vecs [6];

  initial begin
    int stall;
    int u0;
    int t_before;

    vecs[0] = '{16'h0800, 16'h0100};  // ramp up from 0
    vecs[1] = '{16'hF800, 16'h0600};  // signed ramp down, -0x200 per clock
    vecs[2] = '{16'h7FFF, 16'h08FF};  // up to positive full scale
    vecs[3] = '{16'h8000, 16'h5FFF};  // full-scale swing down, floor of negative step
    vecs[4] = '{16'h0003, 16'h9000};  // up from negative full scale
    vecs[5] = '{16'hFFFF, 16'h0002};  // tiny negative step, floor gives -1

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pcm_out", pcm_out, 16'h0000);
    check("reset_s_ready", s_ready, 1'b1);
    check("reset_tick", sample_tick, 1'b0);
    check("reset_underrun", underrun, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Table stream: first sample from IDLE, then the rest held back-to-back
    // so the FIFO fills and the last sample waits for the next wrap pop.
    u0 = n_under;
    send(vecs[0].din, vecs[0].first, stall);
    for (int i = 1; i < 6; i++) begin
      send(vecs[i].din, vecs[i].first, stall);
      if (i == 4) check("full_s_ready_low", s_ready, 1'b0);
      if (i == 5) check("backpressure_stall", stall, 5);
      else        check("no_stall", stall, 0);
    end
    repeat (60) @(posedge clk);
    #1;
    check("stream_drained", sb.size(), 0);
    check("stream_end_underrun", n_under - u0, 1);

    // Starvation: one sample, hold across wraps, then resume on the grid.
    pulse_reset();
    u0 = n_under;
    send(16'h0800, 16'h0100, stall);
    repeat (40) @(posedge clk);
    #1;
    check("starve_underrun_once", n_under - u0, 1);
    check("starve_hold_value", pcm_out, 16'h0800);
    send(16'h0000, 16'h0700, stall);
    repeat (12) @(posedge clk);
    #1;
    check("resume_loaded", sb.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    check("resume_then_starve", n_under - u0, 2);
    check("resume_hold_value", pcm_out, 16'h0000);

    // Reset mid-ramp with two samples still queued.
    pulse_reset();
    send(16'h0400, 16'h0080, stall);
    send(16'h0C00, 16'h0500, stall);
    send(16'h1000, 16'h0C80, stall);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_phase4", pcm_out, 16'h0200);
    check("pre_reset_ready", s_ready, 1'b1);
    rst = 1'b1;
    #1;
    check("async_reset_pcm", pcm_out, 16'h0000);
    check("async_reset_ready", s_ready, 1'b1);
    check("async_reset_tick", sample_tick, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t_before = n_tick;
    repeat (12) @(posedge clk);
    #1;
    check("post_reset_no_tick", n_tick - t_before, 0);
    check("post_reset_pcm", pcm_out, 16'h0000);
    send(16'h0800, 16'h0100, stall);
    check("idle_no_early_tick", sample_tick, 1'b0);
    @(posedge clk);
    #1;
    check("idle_load_tick", sample_tick, 1'b1);
    check("idle_load_pcm", pcm_out, 16'h0000);
    @(posedge clk);
    #1;
    check("idle_first_step", pcm_out, 16'h0100);
    repeat (20) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
